varredura_sensores_temp: RTL and testbench

- Time-multiplexed scan controller for the plant's seven temperature sensors.
- Channels: control room, sectors 1–3, primary tube, secondary tube, reactor.
- Polls each sensor over a shared request/acknowledge sensor bus on a fixed schedule.
- Per channel it applies a confirmation count, hysteresis and timeout fault detection.
- Drives the latched audible temperature alarm, which needs operator acknowledgement to clear.

---
 rtl/temp_pkg.sv | 29 ++
 rtl/avaliador_canal.sv | 62 ++++++
 rtl/varredura_sensores_temp.sv | 148 ++++++++++++++
 tb/tb_varredura_sensores_temp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature sensor scan controller.
//   - channel index constants and channel count
//   - per-channel over-temperature limits (9-bit, degrees C)
//   - scan FSM state encoding
package temp_pkg;

  localparam int NUM_CANAIS = 7;

  localparam logic [2:0] CH_SC    = 3'd0;
  localparam logic [2:0] CH_S1    = 3'd1;
  localparam logic [2:0] CH_S2    = 3'd2;
  localparam logic [2:0] CH_S3    = 3'd3;
  localparam logic [2:0] CH_TUBSR = 3'd4;
  localparam logic [2:0] CH_TUBSS = 3'd5;
  localparam logic [2:0] CH_REA   = 3'd6;

  // Over-limit thresholds indexed by channel number.
  localparam logic [8:0] LIMITES [NUM_CANAIS] = '{
    9'd50, 9'd100, 9'd100, 9'd100, 9'd100, 9'd100, 9'd261
  };

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LEITURA = 2'd1,
    AVALIA  = 2'd2,
    PROXIMO = 2'd3
  } estado_t;

endpackage

// File: rtl/avaliador_canal.sv
// One channel's over-temperature evaluator.
//   en    : one-cycle strobe, dado holds a fresh reading for this channel
//   dado  : 9-bit reading in degrees C
//   sobre : confirmed over-temperature flag
// A reading >= LIMITE counts toward confirmation (saturating at N_CONFIRMA);
// the flag sets when the count reaches N_CONFIRMA. Once set, the flag only
// clears on a reading below LIMITE - HISTERESE (clamped at 0). Readings in
// the band between the two keep a set flag, but reset a pending count.
module avaliador_canal
  import temp_pkg::*;
#(
  parameter int         N_CONFIRMA = 3,
  parameter int         HISTERESE  = 5,
  parameter logic [8:0] LIMITE     = 9'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [8:0] dado,
  output logic       sobre
);

  localparam logic [9:0] LIMITE_10 = {1'b0, LIMITE};
  localparam logic [9:0] LIMIAR    = (LIMITE_10 >= 10'(HISTERESE)) ?
                                     (LIMITE_10 - 10'(HISTERESE)) : 10'd0;
  localparam logic [2:0] N_MAX     = 3'(N_CONFIRMA);

  logic [2:0] cnt_q, cnt_d;
  logic       sobre_q, sobre_d;
  logic [2:0] cnt_inc;

  always_comb begin
    cnt_d   = cnt_q;
    sobre_d = sobre_q;
    cnt_inc = (cnt_q == N_MAX) ? cnt_q : cnt_q + 3'd1;
    if (en) begin
      if (dado >= LIMITE) begin
        cnt_d = cnt_inc;
        if (cnt_inc == N_MAX) sobre_d = 1'b1;
      end else if ({1'b0, dado} < LIMIAR) begin
        cnt_d   = 3'd0;
        sobre_d = 1'b0;
      end else if (!sobre_q) begin
        // Hysteresis band with flag clear: confirmation must restart.
        cnt_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 3'd0;
      sobre_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sobre_q <= sobre_d;
    end
  end

  assign sobre = sobre_q;

endmodule

// File: rtl/varredura_sensores_temp.sv
// Time-multiplexed scan controller for seven temperature sensors.
//   habilita    : enables periodic sweeps (one every PERIODO_VARREDURA cycles)
//   barReq/barAck/barSel/barDado : shared sensor bus
//   reconhece   : operator alarm acknowledge (level)
//   sobreTemp   : per-channel confirmed over-temperature flags
//   falhaSensor : per-channel read-timeout flags
//   alarmeSonoroTemperatura : latched audible alarm
//   fimVarredura: one-cycle pulse when a full sweep completes
//   estado_dbg  : current scan FSM state
// Bus handshake: barReq is high for the whole LEITURA state with barSel
// stable; the sensor answers with barAck=1 and barDado valid in the same
// cycle. barAck is only sampled while barReq=1; without an ack within
// TIMEOUT_LEITURA cycles the channel is flagged faulty and skipped.
module varredura_sensores_temp
  import temp_pkg::*;
#(
  parameter int PERIODO_VARREDURA = 1000,
  parameter int TIMEOUT_LEITURA   = 16,
  parameter int N_CONFIRMA        = 3,
  parameter int HISTERESE         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilita,
  input  logic       barAck,
  input  logic [8:0] barDado,
  input  logic       reconhece,
  output logic       barReq,
  output logic [2:0] barSel,
  output logic [6:0] sobreTemp,
  output logic [6:0] falhaSensor,
  output logic       alarmeSonoroTemperatura,
  output logic       fimVarredura,
  output estado_t    estado_dbg
);

  localparam int TW  = $clog2(PERIODO_VARREDURA + 1);
  localparam int TOW = $clog2(TIMEOUT_LEITURA + 1);

  estado_t          estado_q, estado_d;
  logic [2:0]       idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [TOW-1:0]   tmo_q, tmo_d;
  logic [8:0]       dado_q, dado_d;
  logic [6:0]       falha_q, falha_d;
  logic             alarme_q, alarme_d;
  logic [6:0]       avalia_stb;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      idx_q    <= 3'd0;
      timer_q  <= '0;
      tmo_q    <= '0;
      dado_q   <= 9'd0;
      falha_q  <= 7'd0;
      alarme_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      tmo_q    <= tmo_d;
      dado_q   <= dado_d;
      falha_q  <= falha_d;
      alarme_q <= alarme_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    timer_d  = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    tmo_d    = tmo_q;
    dado_d   = dado_q;
    falha_d  = falha_q;
    case (estado_q)
      OCIOSO: begin
        tmo_d = '0;
        if (habilita && timer_q == '0) begin
          estado_d = LEITURA;
          idx_d    = CH_SC;
          timer_d  = TW'(PERIODO_VARREDURA - 1);
        end
      end
      LEITURA: begin
        if (barAck) begin
          dado_d   = barDado;
          tmo_d    = '0;
          estado_d = AVALIA;
        end else if (tmo_q == TOW'(TIMEOUT_LEITURA - 1)) begin
          // Debounce state of the channel is deliberately left alone.
          falha_d[idx_q] = 1'b1;
          tmo_d          = '0;
          estado_d       = PROXIMO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      AVALIA: begin
        falha_d[idx_q] = 1'b0;
        estado_d       = PROXIMO;
      end
      PROXIMO: begin
        if (!habilita || idx_q == CH_REA) begin
          estado_d = OCIOSO;
        end else begin
          idx_d    = idx_q + 3'd1;
          estado_d = LEITURA;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Flags seen this cycle win over an acknowledge.
    if (|sobreTemp || |falha_q) alarme_d = 1'b1;
    else if (reconhece)         alarme_d = 1'b0;
    else                        alarme_d = alarme_q;
  end

  // Outputs decoded from state.
  always_comb begin
    barReq       = (estado_q == LEITURA);
    fimVarredura = (estado_q == PROXIMO) && habilita && (idx_q == CH_REA);
    avalia_stb   = (estado_q == AVALIA) ? (7'd1 << idx_q) : 7'd0;
  end

  for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
    avaliador_canal #(
      .N_CONFIRMA (N_CONFIRMA),
      .HISTERESE  (HISTERESE),
      .LIMITE     (LIMITES[g])
    ) u_aval (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (avalia_stb[g]),
      .dado  (dado_q),
      .sobre (sobreTemp[g])
    );
  end

  assign barSel                  = idx_q;
  assign falhaSensor             = falha_q;
  assign alarmeSonoroTemperatura = alarme_q;
  assign estado_dbg              = estado_q;

endmodule

// File: tb/tb_varredura_sensores_temp.sv
module tb_varredura_sensores_temp;
  import temp_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       habilita;
  logic       bar_ack;
  logic [8:0] bar_dado;
  logic       reconhece;
  logic       bar_req;
  logic [2:0] bar_sel;
  logic [6:0] sobre_temp;
  logic [6:0] falha_sensor;
  logic       alarme;
  logic       fim_varredura;
  estado_t    estado_dbg;

  always #5 clk = ~clk;

  varredura_sensores_temp dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .habilita                (habilita),
    .barAck                  (bar_ack),
    .barDado                 (bar_dado),
    .reconhece               (reconhece),
    .barReq                  (bar_req),
    .barSel                  (bar_sel),
    .sobreTemp               (sobre_temp),
    .falhaSensor             (falha_sensor),
    .alarmeSonoroTemperatura (alarme),
    .fimVarredura            (fim_varredura),
    .estado_dbg              (estado_dbg)
  );

  // ---------------- check / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  int ciclo = 0;
  int fim_cnt = 0;

  always @(posedge clk) ciclo++;
  always @(negedge clk) if (fim_varredura) fim_cnt++;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, esp, ciclo);
    end
  endtask

  // Reference model of the per-channel debounce/hysteresis and fault flags.
  int         m_cnt[7];
  logic [6:0] m_sobre;
  logic [6:0] m_falha;

  function automatic int lim_tb(input int c);
    if (c == 0) return 50;
    if (c == 6) return 261;
    return 100;
  endfunction

  task automatic modelo(input int c, input int v, input bit ack);
    int lim, thr;
    if (!ack) begin
      m_falha[c] = 1'b1;
    end else begin
      m_falha[c] = 1'b0;
      lim = lim_tb(c);
      thr = (lim >= 5) ? lim - 5 : 0;
      if (v >= lim) begin
        if (m_cnt[c] < 3) m_cnt[c]++;
        if (m_cnt[c] == 3) m_sobre[c] = 1'b1;
      end else if (v < thr) begin
        m_cnt[c] = 0;
        m_sobre[c] = 1'b0;
      end else if (!m_sobre[c]) begin
        m_cnt[c] = 0;
      end
    end
    exp_q.push_back({3'(c), m_falha, m_sobre});
  endtask

  task automatic modelo_reset();
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    m_sobre = 7'd0;
    m_falha = 7'd0;
    exp_q.delete();
  endtask

  // Every channel step lands in PROXIMO; compare the flags produced there.
  always @(negedge clk) begin
    if (rst_n && estado_dbg == PROXIMO) begin
      if (exp_q.size() == 0) begin
        verifica("proximo_inesperado", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        verifica("canal_flags", {15'd0, bar_sel, falha_sensor, sobre_temp}, {15'd0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  int   leit[7];
  logic [6:0] noack;
  int   drop_ch;
  int   fim_ciclo;

  task automatic espera_req(output bit ok);
    int n = 0;
    while (!bar_req && n < 1500) begin
      @(negedge clk);
      n++;
    end
    ok = bar_req;
    if (!ok) verifica("timeout_barReq", 32'd0, 32'd1);
  endtask

  task automatic servir_canal(input int c, input int v, input bit ack, input bit drop);
    bit ok;
    int n;
    espera_req(ok);
    if (!ok) return;
    verifica("barSel", {29'd0, bar_sel}, c);
    if (drop) habilita = 1'b0;
    if (ack) begin
      bar_dado = 9'(v);
      bar_ack  = 1'b1;
      modelo(c, v, 1'b1);
      @(negedge clk);
      bar_ack  = 1'b0;
      bar_dado = 9'd0;
    end else begin
      modelo(c, 0, 1'b0);
      n = 0;
      while (bar_req && n < 40) begin
        @(negedge clk);
        n++;
      end
      verifica("barReq_ciclos_timeout", n, 32'd16);
    end
  endtask

  task automatic varrer();
    bit completa = 1'b1;
    for (int c = 0; c < 7; c++) begin
      servir_canal(c, leit[c], !noack[c], c == drop_ch);
      if (c == drop_ch) begin
        completa = 1'b0;
        break;
      end
    end
    if (completa && !noack[6]) begin
      @(negedge clk);
      verifica("fimVarredura", {31'd0, fim_varredura}, 32'd1);
      fim_ciclo = ciclo;
    end
  endtask

  task automatic leituras(input int v0, input int v6);
    for (int i = 0; i < 7; i++) leit[i] = 20;
    leit[0] = v0;
    leit[6] = v6;
  endtask

  task automatic pulso_reconhece();
    reconhece = 1'b1;
    @(negedge clk);
    reconhece = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ini;
    int fim_antes;
    int req_vistos;
    int rea_seq[6];
    bit ok;

    rea_seq = '{261, 261, 260, 261, 261, 261};
    rst_n = 1'b0; habilita = 1'b0; bar_ack = 1'b0; bar_dado = 9'd0; reconhece = 1'b0;
    noack = 7'd0; drop_ch = -1;
    modelo_reset();
    repeat (3) @(negedge clk);
    verifica("reset_barReq", {31'd0, bar_req}, 32'd0);
    verifica("reset_flags", {18'd0, falha_sensor, sobre_temp}, 32'd0);
    verifica("reset_alarme", {31'd0, alarme}, 32'd0);
    verifica("reset_fim", {31'd0, fim_varredura}, 32'd0);
    verifica("reset_sel", {29'd0, bar_sel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    habilita = 1'b1;

    // Two quiet sweeps; check period between completions.
    leituras(20, 20);
    varrer();
    ini = fim_ciclo;
    verifica("alarme_quieto", {31'd0, alarme}, 32'd0);
    // barAck with no request must be ignored.
    bar_ack = 1'b1; bar_dado = 9'd500;
    repeat (10) @(negedge clk);
    verifica("ack_sem_req", {31'd0, bar_req}, 32'd0);
    bar_ack = 1'b0; bar_dado = 9'd0;
    varrer();
    verifica("periodo_varredura", fim_ciclo - ini, 32'd1000);

    // Reactor confirmation with an interrupting 260 read.
    for (int s = 0; s < 6; s++) begin
      leituras(20, rea_seq[s]);
      varrer();
    end
    verifica("rea_sobre_latencia", {31'd0, sobre_temp[6]}, 32'd1);
    verifica("alarme_antes", {31'd0, alarme}, 32'd0);
    @(negedge clk);
    verifica("alarme_depois", {31'd0, alarme}, 32'd1);

    // Hysteresis hold then clear; alarm latched until acknowledged.
    leituras(20, 258);
    varrer();
    leituras(20, 255);
    varrer();
    @(negedge clk);
    verifica("alarme_travado", {31'd0, alarme}, 32'd1);
    pulso_reconhece();
    verifica("alarme_reconhecido", {31'd0, alarme}, 32'd0);

    // Channel 2 read timeout, then recovery.
    leituras(20, 20);
    noack = 7'b0000100;
    varrer();
    noack = 7'd0;
    verifica("alarme_falha", {31'd0, alarme}, 32'd1);
    varrer();
    @(negedge clk);
    pulso_reconhece();
    verifica("alarme_apos_falha", {31'd0, alarme}, 32'd0);

    // SC over-limit with reconhece held across the setting cycle.
    leituras(50, 20);
    varrer();
    varrer();
    reconhece = 1'b1;
    varrer();
    @(negedge clk);
    verifica("alarme_reconhece_ignorado", {31'd0, alarme}, 32'd1);
    leituras(20, 20);
    varrer();
    @(negedge clk);
    verifica("alarme_limpo_sc", {31'd0, alarme}, 32'd0);
    reconhece = 1'b0;

    // Drop habilita during channel 3's read.
    fim_antes = fim_cnt;
    drop_ch = 3;
    varrer();
    drop_ch = -1;
    req_vistos = 0;
    repeat (1500) begin
      @(negedge clk);
      if (bar_req) req_vistos++;
    end
    verifica("sem_req_apos_desabilitar", req_vistos, 32'd0);
    verifica("sem_fim_apos_desabilitar", fim_cnt - fim_antes, 32'd0);
    verifica("fila_vazia", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a read.
    habilita = 1'b1;
    servir_canal(0, 0, 1'b0, 1'b0);
    espera_req(ok);
    verifica("sel_antes_reset", {29'd0, bar_sel}, 32'd1);
    verifica("falha_antes_reset", {25'd0, falha_sensor}, 32'd1);
    verifica("alarme_antes_reset", {31'd0, alarme}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    verifica("rst_barReq", {31'd0, bar_req}, 32'd0);
    verifica("rst_flags", {18'd0, falha_sensor, sobre_temp}, 32'd0);
    verifica("rst_alarme", {31'd0, alarme}, 32'd0);
    verifica("fila_vazia_reset", exp_q.size(), 32'd0);
    modelo_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
